// File: rtl/reg_writeback.sv
// reg_writeback: in-order write-back queue feeding a register file write port.
// Define REG_WRITEBACK_FWD_EN to add the fwdValid/fwdData forwarding outputs.
module reg_writeback #(
  parameter int W     = 8,
  parameter int D     = 3,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D-1:0]                 in_dest,
  input  logic                         in_port,
  input  logic [W-1:0]                 in_data,
  input  logic                         stall,
  output logic [1:0]                   RegWrite,
  output logic [D-1:0]                 srcA,
  output logic [D-1:0]                 srcB,
  output logic [W-1:0]                 writeValue,
  input  logic [D-1:0]                 qAddr,
  output logic                         qHazard,
`ifdef REG_WRITEBACK_FWD_EN
  output logic                         fwdValid,
  output logic [W-1:0]                 fwdData,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [D-1:0]  destMem [DEPTH];
  logic          portMem [DEPTH];
  logic [W-1:0]  dataMem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic          push, pop;
  assign in_ready = count != CW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !stall;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // Entry storage is left uncleared; validity comes only from count/rdPtr.
  always_ff @(posedge CLK)
    if (push) begin
      destMem[wrPtr] <= in_dest;
      portMem[wrPtr] <= in_port;
      dataMem[wrPtr] <= in_data;
    end
  assign RegWrite   = pop ? (portMem[rdPtr] ? 2'b10 : 2'b01) : 2'b00;
  assign srcA       = RegWrite[0] ? destMem[rdPtr] : '0;
  assign srcB       = RegWrite[1] ? destMem[rdPtr] : '0;
  assign writeValue = pop ? dataMem[rdPtr] : '0;
  always_comb begin
    qHazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count && destMem[rdPtr + PW'(i)] == qAddr) qHazard = 1'b1;
  end
`ifdef REG_WRITEBACK_FWD_EN
  assign fwdValid = qHazard;
  // Scanning oldest to youngest lets the youngest match win.
  always_comb begin
    fwdData = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < count && destMem[rdPtr + PW'(i)] == qAddr) fwdData = dataMem[rdPtr + PW'(i)];
  end
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed vector table, hand sequences and randomized traffic
// checked against a queue-based reference model.
module tb_reg_writeback;
  localparam int W = 8;
  localparam int D = 3;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = 2 + D + D + W + CW + 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [D-1:0]  in_dest = '0;
  logic          in_port = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          stall = 1'b0;
  logic [1:0]    RegWrite;
  logic [D-1:0]  srcA, srcB;
  logic [W-1:0]  writeValue;
  logic [D-1:0]  qAddr = '0;
  logic          qHazard;
  logic [CW-1:0] count;
`ifdef REG_WRITEBACK_FWD_EN
  logic          fwdValid;
  logic [W-1:0]  fwdData;
`endif

  reg_writeback #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_port(in_port), .in_data(in_data), .stall(stall),
    .RegWrite(RegWrite), .srcA(srcA), .srcB(srcB), .writeValue(writeValue),
    .qAddr(qAddr), .qHazard(qHazard),
`ifdef REG_WRITEBACK_FWD_EN
    .fwdValid(fwdValid), .fwdData(fwdData),
`endif
    .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [D-1:0] dest;
    logic         port;
    logic [W-1:0] data;
  } entry_t;

  typedef struct {
    logic         v;
    logic [D-1:0] d;
    logic         p;
    logic [W-1:0] x;
    logic         s;
    logic [D-1:0] qa;
    logic [1:0]   eRw;
    logic [D-1:0] eA;
    logic [D-1:0] eB;
    logic [W-1:0] eWv;
    int           eCnt;
    logic         eRdy;
    logic         eHaz;
  } vec_t;

  entry_t mq[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [TW-1:0] actual();
    return {RegWrite, srcA, srcB, writeValue, count, in_ready, qHazard};
  endfunction

  task automatic cmp(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got rw/a/b/wv/cnt/rdy/haz=%h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs from the abstract queue model for the current inputs.
  task automatic modelCheck(input string name);
    logic [1:0]   rw;
    logic [D-1:0] a, b;
    logic [W-1:0] wv;
    logic         haz;
    rw = 2'b00; a = '0; b = '0; wv = '0; haz = 1'b0;
    if (mq.size() > 0 && !stall) begin
      wv = mq[0].data;
      if (mq[0].port) begin rw = 2'b10; b = mq[0].dest; end
      else begin rw = 2'b01; a = mq[0].dest; end
    end
    foreach (mq[k]) if (mq[k].dest == qAddr) haz = 1'b1;
    cmp(name, actual(), {rw, a, b, wv, CW'(mq.size()), mq.size() < DEPTH, haz});
`ifdef REG_WRITEBACK_FWD_EN
    begin
      logic [W-1:0] fd;
      fd = '0;
      foreach (mq[k]) if (mq[k].dest == qAddr) fd = mq[k].data;
      vectors++;
      if ({fwdValid, fwdData} !== {haz, fd}) begin
        miscompares++;
        $display("FAIL %s_fwd: got %b/%h required %b/%h", name, fwdValid, fwdData, haz, fd);
      end
    end
`endif
  endtask

  task automatic drive(input logic v, input logic [D-1:0] d, input logic p,
                       input logic [W-1:0] x, input logic s, input logic [D-1:0] qa);
    in_valid = v; in_dest = d; in_port = p; in_data = x; stall = s; qAddr = qa;
    #1;
  endtask

  // Take one clock edge and apply the queue rules to the model.
  task automatic advance();
    logic doPop, doPush;
    @(posedge CLK);
    doPop  = mq.size() > 0 && !stall;
    doPush = in_valid && mq.size() < DEPTH;
    if (doPop) void'(mq.pop_front());
    if (doPush) mq.push_back('{in_dest, in_port, in_data});
    @(negedge CLK);
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{1, 5, 0, 8'hA5, 0, 0, 2'b00, 0, 0, 8'h00, 0, 1, 0},
      '{0, 0, 0, 8'h00, 0, 5, 2'b01, 5, 0, 8'hA5, 1, 1, 1},
      '{0, 0, 0, 8'h00, 0, 5, 2'b00, 0, 0, 8'h00, 0, 1, 0},
      '{1, 1, 0, 8'h11, 1, 1, 2'b00, 0, 0, 8'h00, 0, 1, 0},
      '{1, 2, 0, 8'h22, 1, 1, 2'b00, 0, 0, 8'h00, 1, 1, 1},
      '{1, 3, 0, 8'h33, 1, 1, 2'b00, 0, 0, 8'h00, 2, 1, 1},
      '{1, 4, 0, 8'h44, 1, 4, 2'b00, 0, 0, 8'h00, 3, 1, 0},
      '{1, 7, 0, 8'h77, 1, 4, 2'b00, 0, 0, 8'h00, 4, 0, 1},
      '{0, 0, 0, 8'h00, 0, 0, 2'b01, 1, 0, 8'h11, 4, 0, 0},
      '{0, 0, 0, 8'h00, 0, 0, 2'b01, 2, 0, 8'h22, 3, 1, 0},
      '{0, 0, 0, 8'h00, 0, 0, 2'b01, 3, 0, 8'h33, 2, 1, 0},
      '{0, 0, 0, 8'h00, 0, 7, 2'b01, 4, 0, 8'h44, 1, 1, 0},
      '{0, 0, 0, 8'h00, 0, 7, 2'b00, 0, 0, 8'h00, 0, 1, 0},
      '{1, 3, 1, 8'h3C, 1, 3, 2'b00, 0, 0, 8'h00, 0, 1, 0},
      '{0, 0, 0, 8'h00, 1, 3, 2'b00, 0, 0, 8'h00, 1, 1, 1},
      '{0, 0, 0, 8'h00, 1, 2, 2'b00, 0, 0, 8'h00, 1, 1, 0},
      '{0, 0, 0, 8'h00, 0, 3, 2'b10, 0, 3, 8'h3C, 1, 1, 1},
      '{0, 0, 0, 8'h00, 0, 3, 2'b00, 0, 0, 8'h00, 0, 1, 0}
    };

    #2;
    cmp("reset_state", actual(), {2'b00, D'(0), D'(0), W'(0), CW'(0), 1'b1, 1'b0});
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].x, tbl[i].s, tbl[i].qa);
      cmp($sformatf("table_%0d", i), actual(),
          {tbl[i].eRw, tbl[i].eA, tbl[i].eB, tbl[i].eWv, CW'(tbl[i].eCnt), tbl[i].eRdy, tbl[i].eHaz});
      advance();
    end

    // Steady push+pop at count=2 walks the pointers around several times.
    drive(1, 1, 0, 8'hC1, 1, 0); advance();
    drive(1, 2, 1, 8'hC2, 1, 0); advance();
    for (int i = 0; i < 10; i++) begin
      drive(1, D'(i), i[0], W'(8'hD0 + i), 0, D'(i + 1));
      modelCheck($sformatf("steady_%0d", i));
      if (count != CW'(2)) begin
        miscompares++;
        $display("FAIL steady_count_%0d: got %0d required 2", i, count);
      end
      vectors++;
      advance();
    end
    drive(0, 0, 0, 0, 0, 0);
    while (mq.size() > 0) begin modelCheck("drain"); advance(); end

    // Asynchronous reset between edges with three entries pending.
    for (int i = 0; i < 3; i++) begin drive(1, D'(i + 2), 0, W'(8'hE0 + i), 1, 0); advance(); end
    drive(0, 0, 0, 0, 0, 2);
    #2 RST_N = 1'b0;
    #1 cmp("async_reset", actual(), {2'b00, D'(0), D'(0), W'(0), CW'(0), 1'b1, 1'b0});
    mq.delete();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 2); modelCheck("post_reset"); advance(); end

`ifdef REG_WRITEBACK_FWD_EN
    drive(1, 6, 0, 8'h10, 1, 6); advance();
    drive(1, 6, 0, 8'h20, 1, 6); advance();
    drive(0, 0, 0, 0, 1, 6);
    vectors++;
    if ({fwdValid, fwdData} !== {1'b1, 8'h20}) begin
      miscompares++;
      $display("FAIL fwd_youngest: got %b/%h required 1/20", fwdValid, fwdData);
    end
    modelCheck("fwd_model");
    drive(0, 0, 0, 0, 0, 0);
    while (mq.size() > 0) begin modelCheck("fwd_drain"); advance(); end
`endif

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, D'($urandom_range(0, 2**D - 1)), 1'($urandom_range(0, 1)),
            W'($urandom_range(0, 255)), $urandom_range(0, 9) < 3, D'($urandom_range(0, 2**D - 1)));
      modelCheck($sformatf("random_%0d", i));
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter W, default 8: data width, matches the register file word width.
REQ-002 Parameter D, default 3: register address width (2**D registers).
REQ-003 Parameter DEPTH, default 4: write-queue entries, power of two and at least 2.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports CLK and RST_N.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  producer offers a write result.
REQ-008 in_ready  output  1  queue can accept; equals not full.
REQ-009 in_dest  input  D  destination register address.
REQ-010 in_port  input  1  0 = issue via srcA slot (RegWrite 01), 1 = via srcB slot (RegWrite 10).
REQ-011 in_data  input  W  value to write.
REQ-012 stall  input  1  inhibits draining this cycle.
REQ-013 RegWrite  output  2  register-file write strobe: 00 none, 01 srcA, 10 srcB; never 11.
REQ-014 srcA  output  D  write address when RegWrite=01, else 0.
REQ-015 srcB  output  D  write address when RegWrite=10, else 0.
REQ-016 writeValue  output  W  head data when writing, else 0.
REQ-017 qAddr  input  D  read address probed for pending writes.
REQ-018 qHazard  output  1  some queued entry targets qAddr.
REQ-019 count  output  clog2(DEPTH+1)  number of queued entries.

Function
REQ-020 A push SHALL occur on a rising CLK edge when in_valid and in_ready are both 1; the entry {in_dest, in_port, in_data} is appended at the tail.
REQ-021 The queue SHALL be strictly FIFO; the head drives the write outputs combinationally.
REQ-022 When count>0 and stall=0, RegWrite SHALL be 01 (head port 0) or 10 (head port 1), and the head SHALL pop on that edge.
REQ-023 When count=0 or stall=1: RegWrite=00, srcA=srcB=0, writeValue=0, no pop.
REQ-024 Minimum latency: an entry pushed at edge N SHALL be written to the register file at edge N+1 (empty queue, stall=0).
REQ-025 Full (count=DEPTH): in_ready=0; in_valid is ignored even if a pop occurs the same cycle.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entry.
REQ-028 qHazard SHALL be combinational: 1 if any valid entry, including the head being written this cycle, has dest == qAddr.
REQ-029 Entries with the same dest SHALL all be issued in order; no coalescing.

Reset
REQ-030 RST_N=0 SHALL immediately, asynchronously empty the queue: count=0, in_ready=1, RegWrite=00, srcA=srcB=0, writeValue=0, qHazard=0.
REQ-031 Reset mid-operation SHALL discard all pending entries; none is written after release.
REQ-032 Entry storage need not be cleared; only valid/pointer state is reset.

Configuration
REQ-033 Macro REG_WRITEBACK_FWD_EN: when defined, add outputs fwdValid (1) and fwdData (W); fwdValid = qHazard, and fwdData is the data of the youngest queued entry with dest == qAddr, else 0.
REQ-034 Without REG_WRITEBACK_FWD_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset, then push dest=5 port=0 data=0xA5, stall=0 -> next cycle RegWrite=01, srcA=5, writeValue=0xA5; following cycle RegWrite=00, count=0.
REQ-036 stall=1, push 4 entries (dest 1..4, data 0x11..0x44) -> count=4, in_ready=0, 5th push ignored; release stall -> four writes in order 1..4 on consecutive cycles.
REQ-037 Push dest=3 port=1 data=0x3C with stall=1, qAddr=3 -> qHazard=1; qAddr=2 -> qHazard=0; release -> RegWrite=10, srcB=3.
REQ-038 Queue at count=2 with concurrent push and pop for 10 cycles -> count stays 2, pointers wrap, output order equals input order.
REQ-039 count=3, assert RST_N=0 asynchronously between edges -> RegWrite=00 and count=0 before the next edge; no queued value is written after release.
REQ-040 With REG_WRITEBACK_FWD_EN: queue dest=6 data=0x10 then dest=6 data=0x20 under stall, qAddr=6 -> fwdValid=1, fwdData=0x20.
